// File: rtl/ee93_seq.sv
// rtl/ee93_seq.sv - Microwire 93xx EEPROM command sequencer (frame gen, read shift, busy poll)
// Build option EE93_AUTO_EWEN_EN wraps erase/write ops in EWEN ... EWDS frames.
module ee93_seq #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int BUSY_MAX = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

`ifdef EE93_AUTO_EWEN_EN
  localparam bit AUTO_EWEN = 1'b1;
`else
  localparam bit AUTO_EWEN = 1'b0;
`endif

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;
  localparam logic [2:0] OP_ERAL  = 3'd5;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam int TX_W = 3 + ADDR_W + DATA_W;
  localparam int BC_W = $clog2(TX_W + 1);
  localparam int DV_W = $clog2(2 * CLK_DIV);
  localparam int PC_W = $clog2(BUSY_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_OUT, SHIFT_IN, DESEL, POLL, RESP} state_t;
  typedef enum logic [1:0] {ST_EWEN, ST_OP, ST_EWDS} stage_t;

  state_t            state, state_nxt, desel_to;
  stage_t            stage;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [TX_W-1:0]   tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BC_W-1:0]   out_left, in_left;
  logic [DV_W-1:0]   div_cnt;
  logic [PC_W-1:0]   poll_cnt;
  logic              sk_hi, err_q;

  logic              accept, frame_done, poll_done, timeout, load_en;
  logic [2:0]        load_op;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              div_last, desel_last, hi_end;

  // Start bit, 2-bit opcode, address field, data field (zero unless WRITE/WRAL), MSB first.
  function automatic logic [TX_W-1:0] build_frame(input logic [2:0] op,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] d);
    logic [1:0]        opc;
    logic [ADDR_W-1:0] fa;
    logic [DATA_W-1:0] fd;
    opc = 2'b00;
    fa  = a;
    fd  = '0;
    case (op)
      OP_READ:  opc = 2'b10;
      OP_WRITE: begin opc = 2'b01; fd = d; end
      OP_ERASE: opc = 2'b11;
      default: begin
        fa = '0;
        case (op)
          OP_EWEN: fa[ADDR_W-1 -: 2] = 2'b11;
          OP_ERAL: fa[ADDR_W-1 -: 2] = 2'b10;
          OP_WRAL: begin fa[ADDR_W-1 -: 2] = 2'b01; fd = d; end
          default: ;
        endcase
      end
    endcase
    return {1'b1, opc, fa, fd};
  endfunction

  function automatic logic [BC_W-1:0] out_len(input logic [2:0] op);
    logic [BC_W-1:0] n;
    n = BC_W'(3 + ADDR_W);
    if (op == OP_WRITE || op == OP_WRAL) n = n + BC_W'(DATA_W);
    return n;
  endfunction

  function automatic logic [BC_W-1:0] in_len(input logic [2:0] op);
    return (op == OP_READ) ? BC_W'(DATA_W + 1) : '0;
  endfunction

  function automatic logic is_polled(input logic [2:0] op);
    return (op == OP_WRITE) || (op == OP_ERASE) || (op == OP_ERAL) || (op == OP_WRAL);
  endfunction

  assign div_last   = (div_cnt == DV_W'(CLK_DIV - 1));
  assign desel_last = (div_cnt == DV_W'(2 * CLK_DIV - 1));
  assign hi_end     = sk_hi && div_last;
  assign ld_addr    = accept ? cmd_addr : addr_q;
  assign ld_data    = accept ? cmd_wdata : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ee_cs      = 1'b0;
    ee_sk      = 1'b0;
    ee_di      = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    poll_done  = 1'b0;
    timeout    = 1'b0;
    load_en    = 1'b0;
    load_op    = op_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          load_en   = 1'b1;
          load_op   = (AUTO_EWEN && is_polled(cmd_op)) ? OP_EWEN : cmd_op;
          state_nxt = (cmd_op == OP_RSVD) ? RESP : SETUP;
        end
      end
      SETUP: begin
        ee_cs = 1'b1;
        ee_di = tx_sr[TX_W-1];
        if (div_last) state_nxt = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        ee_cs = 1'b1;
        ee_sk = sk_hi;
        ee_di = tx_sr[TX_W-1];
        if (!sk_hi && div_last && out_left == '0) begin
          if (in_left != '0) state_nxt = SHIFT_IN;
          else               frame_done = 1'b1;
        end
      end
      SHIFT_IN: begin
        ee_cs = 1'b1;
        ee_sk = sk_hi;
        if (!sk_hi && div_last && in_left == '0) frame_done = 1'b1;
      end
      DESEL: if (desel_last) state_nxt = desel_to;
      POLL: begin
        ee_cs = 1'b1;
        if (div_last) begin
          if (ee_do) begin
            poll_done = 1'b1;
          end else if (poll_cnt == PC_W'(BUSY_MAX - 1)) begin
            poll_done = 1'b1;
            timeout   = 1'b1;
          end
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = DESEL;
      end
      default: state_nxt = IDLE;
    endcase
    if (frame_done) begin
      if (stage == ST_EWEN) begin
        state_nxt = DESEL;
        load_en   = 1'b1;
        load_op   = op_q;
      end else if (stage == ST_OP && is_polled(op_q)) begin
        state_nxt = DESEL;
      end else begin
        state_nxt = RESP;
      end
    end
    // Self-timed op finished (ready or timed out): EWDS still goes out in auto mode.
    if (poll_done) begin
      if (AUTO_EWEN) begin
        state_nxt = DESEL;
        load_en   = 1'b1;
        load_op   = OP_EWDS;
      end else begin
        state_nxt = RESP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desel_to  <= IDLE;
      stage     <= ST_OP;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      out_left  <= '0;
      in_left   <= '0;
      div_cnt   <= '0;
      poll_cnt  <= '0;
      sk_hi     <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state_nxt != state || (div_last && state != DESEL)) div_cnt <= '0;
      else                                                   div_cnt <= div_cnt + 1'b1;

      if (state == SETUP && div_last)                                  sk_hi <= 1'b1;
      else if ((state == SHIFT_OUT || state == SHIFT_IN) && div_last) sk_hi <= ~sk_hi;

      if (load_en) begin
        tx_sr    <= build_frame(load_op, ld_addr, ld_data);
        out_left <= out_len(load_op);
        in_left  <= in_len(load_op);
      end else if (state == SHIFT_OUT && hi_end) begin
        tx_sr    <= tx_sr << 1;
        out_left <= out_left - 1'b1;
      end

      // First bit shifted in is the dummy 0; data keeps being captured even if it was 1.
      if (state == SHIFT_IN && hi_end) begin
        rx_sr   <= {rx_sr[DATA_W-2:0], ee_do};
        in_left <= in_left - 1'b1;
        if (in_left == BC_W'(DATA_W + 1) && ee_do) err_q <= 1'b1;
      end

      if (accept) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        data_q <= cmd_wdata;
        err_q  <= 1'b0;
        stage  <= (AUTO_EWEN && is_polled(cmd_op)) ? ST_EWEN : ST_OP;
      end
      if (timeout) err_q <= 1'b1;

      if (frame_done && stage == ST_EWEN) begin
        stage    <= ST_OP;
        desel_to <= SETUP;
      end else if (frame_done && stage == ST_OP && is_polled(op_q)) begin
        desel_to <= POLL;
      end
      if (poll_done && AUTO_EWEN) begin
        stage    <= ST_EWDS;
        desel_to <= SETUP;
      end
      if (state == RESP) desel_to <= IDLE;

      if (state != POLL)             poll_cnt <= '0;
      else if (div_last && !ee_do)   poll_cnt <= poll_cnt + 1'b1;

      if (state_nxt == RESP && state != RESP) begin
        rsp_err <= err_q | timeout | (state == IDLE);
        if (state != IDLE && op_q == OP_READ) rsp_rdata <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_ee93_seq.sv
// tb/tb_ee93_seq.sv - directed self-checking bench for ee93_seq with a behavioural 93C46 pin model
module tb_ee93_seq;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int CD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          valid_a, valid_b;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          ee_do;
  logic          a_ready, a_rv, a_re, a_cs, a_sk, a_di;
  logic          b_ready, b_rv, b_re, b_cs, b_sk, b_di;
  logic [DW-1:0] a_rd, b_rd;
  logic          sel;
  logic          p_ready, p_rv, p_re, p_cs, p_sk, p_di;
  logic [DW-1:0] p_rd;

  assign p_ready = sel ? b_ready : a_ready;
  assign p_rv    = sel ? b_rv    : a_rv;
  assign p_re    = sel ? b_re    : a_re;
  assign p_cs    = sel ? b_cs    : a_cs;
  assign p_sk    = sel ? b_sk    : a_sk;
  assign p_di    = sel ? b_di    : a_di;
  assign p_rd    = sel ? b_rd    : a_rd;

  ee93_seq dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid_a), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_err(a_re),
    .ee_cs(a_cs), .ee_sk(a_sk), .ee_di(a_di), .ee_do(ee_do)
  );

  ee93_seq #(.BUSY_MAX(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid_b), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_err(b_re),
    .ee_cs(b_cs), .ee_sk(b_sk), .ee_di(b_di), .ee_do(ee_do)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0, frames = 0, cmd_frames = 0, fi = 0, j = 0, k = 0;
  int lowcnt = 0, gap = -1, poll_cyc = 0, rsp_cnt = 0, rsp_cyc = -1, ready_dly = -1;
  int busy_n = 1000000;
  logic [63:0]   fbits [4];
  int            fcnt [4];
  logic [DW-1:0] rsp_d;
  logic          rsp_e;
  logic          rd_mode = 1'b0;
  logic [DW:0]   rd_word = '0;
  logic          pcs = 1'b0, psk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe pins just after the edge, then drive ee_do for the next sample.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (p_cs && !pcs) begin
      frames++;
      j = 0;
      k = 0;
      gap = lowcnt;
      lowcnt = 0;
      ee_do = 1'b0;
    end else if (p_cs) begin
      j++;
    end
    if (!p_cs) lowcnt++;
    if (!p_cs && pcs && k == 0) poll_cyc = j + 1;
    if (p_cs && p_sk && !psk) begin
      if (k == 0) begin
        fi = cmd_frames;
        cmd_frames++;
      end
      k++;
      if (fi < 4) begin
        fbits[fi] = {fbits[fi][62:0], p_di};
        fcnt[fi]++;
      end
      if (rd_mode && k >= 10 && k <= 26) ee_do = rd_word[26-k];
    end
    if (p_cs && k == 0) ee_do = ((j / CD) >= busy_n);
    if (!p_cs) ee_do = 1'b0;
    if (p_rv) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_d = p_rd;
      rsp_e = p_re;
    end
    pcs = p_cs;
    psk = p_sk;
  endtask

  task automatic clear_stats();
    cyc = 0; frames = 0; cmd_frames = 0; fi = 0; k = 0; lowcnt = 0; gap = -1;
    poll_cyc = 0; rsp_cnt = 0; rsp_cyc = -1; ready_dly = -1;
    for (int i = 0; i < 4; i++) begin
      fbits[i] = '0;
      fcnt[i] = 0;
    end
  endtask

  task automatic run(input logic use_b, input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    sel = use_b;
    #1;
    n = 0;
    while (!p_ready && n < 200) begin step(); n++; end
    chk("idle_before_cmd", {31'd0, p_ready}, 1);
    clear_stats();
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    if (use_b) valid_b = 1'b1;
    else       valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    valid_b = 1'b0;
    n = 0;
    while (rsp_cnt == 0 && n < 20000) begin step(); n++; end
    n = 0;
    while (!p_ready && n < 100) begin step(); n++; end
    ready_dly = cyc - rsp_cyc;
    chk("rsp_count", rsp_cnt, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    sel = 1'b0;
    ee_do = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", {31'd0, p_cs}, 0);
    chk("reset_sk", {31'd0, p_sk}, 0);
    chk("reset_di", {31'd0, p_di}, 0);
    chk("reset_rsp_valid", {31'd0, p_rv}, 0);
    chk("reset_rdata", {16'd0, p_rd}, 0);
    chk("reset_err", {31'd0, p_re}, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, p_ready}, 1);

    // READ 0x15, dummy 0 then 0xA5C3
    rd_mode = 1'b1;
    rd_word = {1'b0, 16'hA5C3};
    busy_n = 1000000;
    run(1'b0, 3'd0, 6'h15, 16'h0000);
    chk("read_rsp_cycle", rsp_cyc, 213);
    chk("read_rdata", {16'd0, rsp_d}, 32'hA5C3);
    chk("read_err", {31'd0, rsp_e}, 0);
    chk("read_frames", cmd_frames, 1);
    chk("read_bitcount", fcnt[0], 26);
    chk("read_di_bits", fbits[0][31:0], {6'd0, 1'b1, 2'b10, 6'h15, 17'd0});
    chk("read_ready_delay", ready_dly, 9);

    // WRITE 0x3F <- 0x1234, device busy for 50 polls
    rd_mode = 1'b0;
    busy_n = 50;
    run(1'b0, 3'd1, 6'h3F, 16'h1234);
`ifdef EE93_AUTO_EWEN_EN
    chk("auto_frames", cmd_frames, 3);
    chk("auto_ewen_bits", fbits[0][31:0], {23'd0, 1'b1, 2'b00, 6'b110000});
    chk("auto_ewen_len", fcnt[0], 9);
    chk("auto_write_bits", fbits[1][31:0], {7'd0, 1'b1, 2'b01, 6'h3F, 16'h1234});
    chk("auto_ewds_bits", fbits[2][31:0], {23'd0, 1'b1, 2'b00, 6'b000000});
    chk("auto_ewds_len", fcnt[2], 9);
`else
    chk("write_frames", cmd_frames, 1);
    chk("write_di_bits", fbits[0][31:0], {7'd0, 1'b1, 2'b01, 6'h3F, 16'h1234});
    chk("write_bitcount", fcnt[0], 25);
`endif
    chk("write_cs_low_gap", gap, 8);
    chk("write_poll_samples", poll_cyc / CD, 51);
    chk("write_err", {31'd0, rsp_e}, 0);
    chk("write_rdata_hold", {16'd0, rsp_d}, 32'hA5C3);

    // ERASE on the BUSY_MAX=16 instance, device stuck busy
    busy_n = 1000000;
    run(1'b1, 3'd2, 6'h05, 16'h0000);
    chk("erase_poll_samples", poll_cyc / CD, 16);
    chk("erase_err", {31'd0, rsp_e}, 1);
    chk("erase_cs_after", {31'd0, p_cs}, 0);
    chk("erase_ready_delay", ready_dly, 9);

    // Reserved op: no pin activity, immediate error response
    run(1'b0, 3'd7, 6'h00, 16'h0000);
    chk("rsvd_rsp_cycle", rsp_cyc, 1);
    chk("rsvd_err", {31'd0, rsp_e}, 1);
    chk("rsvd_no_cs", frames, 0);
    chk("rsvd_ready_delay", ready_dly, 9);

    // READ with a dummy bit of 1
    rd_mode = 1'b1;
    rd_word = {1'b1, 16'h5A3C};
    run(1'b0, 3'd0, 6'h2A, 16'h0000);
    chk("dummy1_err", {31'd0, rsp_e}, 1);
    chk("dummy1_rdata", {16'd0, rsp_d}, 32'h5A3C);
    chk("dummy1_rsp_cycle", rsp_cyc, 213);

    // Reset pulse in the middle of a WRITE frame
    rd_mode = 1'b0;
    busy_n = 1000000;
    sel = 1'b0;
    clear_stats();
    cmd_op = 3'd1;
    cmd_addr = 6'h01;
    cmd_wdata = 16'hFFFF;
    valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    n = 0;
    while (k < 15 && n < 2000) begin step(); n++; end
    chk("midframe_reached", k, 15);
    chk("midframe_cs_high", {31'd0, p_cs}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_cs", {31'd0, p_cs}, 0);
    chk("midreset_sk", {31'd0, p_sk}, 0);
    chk("midreset_di", {31'd0, p_di}, 0);
    chk("midreset_rdata", {16'd0, p_rd}, 0);
    chk("midreset_err", {31'd0, p_re}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("midreset_ready", {31'd0, p_ready}, 1);

    rd_mode = 1'b1;
    rd_word = {1'b0, 16'h0F0F};
    run(1'b0, 3'd0, 6'h15, 16'h0000);
    chk("post_reset_read_cycle", rsp_cyc, 213);
    chk("post_reset_read_rdata", {16'd0, rsp_d}, 32'h0F0F);
    chk("post_reset_read_err", {31'd0, rsp_e}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
